// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
//   Wide-to-narrow ready/valid width converter. Accepts one
//   DATA_WIDTH*RATIO word and emits RATIO beats of DATA_WIDTH, LSB slice
//   first. The final beat of each word is flagged with last_out. A new word
//   can be accepted in the same cycle the final beat leaves, so the output
//   runs at one beat per cycle with no bubble between words.
//
// Ports
//   clk        in   1                 clock, all state on rising edge
//   reset_n    in   1                 asynchronous reset, active low
//   valid_in   in   1                 upstream word valid
//   data_in    in   DATA_WIDTH*RATIO  upstream word
//   ready_out  out  1                 upstream may transfer (combinational)
//   valid_out  out  1                 downstream beat valid
//   data_out   out  DATA_WIDTH        downstream beat
//   last_out   out  1                 high on the final beat of a word
//   ready_in   in   1                 downstream ready
// -----------------------------------------------------------------------------
module stream_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH*RATIO-1:0]   data_in,
    output logic                          ready_out,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          last_out,
    input  logic                          ready_in
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_s;
    logic [DATA_WIDTH*RATIO-1:0]   word_r;
    logic [DATA_WIDTH*RATIO-1:0]   word_s;
    logic [CNT_W-1:0]              cnt_r;
    logic [CNT_W-1:0]              cnt_s;
    logic                          busy_s;
    logic                          last_beat_s;
    logic                          acc_s;
    logic                          snd_s;

    assign busy_s      = (state_r == SEND);
    assign last_beat_s = (cnt_r == LAST_CNT);

    // Upstream is ready when idle, or when the last beat is leaving this cycle;
    // gating with reset_n keeps ready low for the whole reset window.
    assign ready_out = reset_n & (~busy_s | (ready_in & last_beat_s));
    assign valid_out = busy_s;
    assign last_out  = busy_s & last_beat_s;
    // cnt_r never exceeds RATIO-1, so the slice always stays inside word_r.
    assign data_out  = word_r[int'(cnt_r)*DATA_WIDTH +: DATA_WIDTH];

    assign acc_s = valid_in & ready_out;
    assign snd_s = valid_out & ready_in;

    // Next-state logic: word load, beat counter advance and IDLE/SEND control.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    word_s  = data_in;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (snd_s) begin
                    if (!last_beat_s) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else if (acc_s) begin
                        // Chain the next word directly behind the last beat.
                        word_s  = data_in;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = SEND;
                    end else begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                word_s  = {(DATA_WIDTH*RATIO){1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            word_r  <= {(DATA_WIDTH*RATIO){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule
